// File: rtl/typed_ops_pkg.sv
// typed_ops_pkg: shared FSM state type and width-agnostic sign helpers for the typed divider
package typed_ops_pkg;
  localparam int MAX_W = 128;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} div_state_e;
  function automatic logic [MAX_W-1:0] neg_wrap(input logic [MAX_W-1:0] value);
    return ~value + MAX_W'(1);
  endfunction
  // Callers sign-extend signed operands to MAX_W so the top bit is the sign.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value, input logic is_signed);
    return (is_signed && value[MAX_W-1]) ? neg_wrap(value) : value;
  endfunction
endpackage

// File: rtl/typed_div_step.sv
// typed_div_step: one combinational restoring shift-subtract step
module typed_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             quot_bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted, diff;
  always_comb begin
    shifted = {rem_in, quot_bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/typed_div_seq.sv
// typed_div_seq: iterative radix-2 signed/unsigned divider with valid/ready handshakes
// TYPED_DIV_OVF_FLAG_EN adds out_ovf flagging signed MIN / -1.
module typed_div_seq
  import typed_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
`ifdef TYPED_DIV_OVF_FLAG_EN
  output logic             out_dbz,
  output logic             out_ovf
`else
  output logic             out_dbz
`endif
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, out_quot_q, out_quot_d, out_rem_q, out_rem_d;
  logic [WIDTH:0] rem_q, rem_d, step_rem;
  logic sgn_q, sgn_d, nq_q, nq_d, nr_q, nr_d, dbz_q, dbz_d, out_dbz_q, out_dbz_d, step_bit;

  typed_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem_q), .quot_bit_in(quo_q[WIDTH-1]), .divisor(b_q),
    .rem_out(step_rem), .q_bit(step_bit)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = in_valid ? PREP : IDLE;
      PREP:    state_d = (b_q == '0) ? FIX : ITER;
      ITER:    state_d = (cnt_q == '0) ? FIX : ITER;
      FIX:     state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    nq_d = nq_q;
    nr_d = nr_q;
    dbz_d = dbz_q;
    out_quot_d = out_quot_q;
    out_rem_d = out_rem_q;
    out_dbz_d = out_dbz_q;
    if (state_q == IDLE && in_valid) begin
      a_d = in_dividend;
      b_d = in_divisor;
      sgn_d = in_signed;
    end
    // quo_q first holds the dividend magnitude, shifted out as quotient bits shift in
    if (state_q == PREP) begin
      quo_d = WIDTH'(abs_val(sgn_q ? MAX_W'($signed(a_q)) : MAX_W'(a_q), sgn_q));
      b_d = WIDTH'(abs_val(sgn_q ? MAX_W'($signed(b_q)) : MAX_W'(b_q), sgn_q));
      rem_d = '0;
      cnt_d = CNT_W'(WIDTH - 1);
      nq_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      nr_d = sgn_q & a_q[WIDTH-1];
      dbz_d = b_q == '0;
    end
    if (state_q == ITER) begin
      rem_d = step_rem;
      quo_d = {quo_q[WIDTH-2:0], step_bit};
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
    end
    if (state_q == FIX) begin
      out_quot_d = dbz_q ? '1 : nq_q ? WIDTH'(neg_wrap(MAX_W'(quo_q))) : quo_q;
      out_rem_d = dbz_q ? a_q : nr_q ? WIDTH'(neg_wrap(MAX_W'(rem_q[WIDTH-1:0]))) : rem_q[WIDTH-1:0];
      out_dbz_d = dbz_q;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      sgn_q <= 1'b0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      dbz_q <= 1'b0;
      out_quot_q <= '0;
      out_rem_q <= '0;
      out_dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      sgn_q <= sgn_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      dbz_q <= dbz_d;
      out_quot_q <= out_quot_d;
      out_rem_q <= out_rem_d;
      out_dbz_q <= out_dbz_d;
    end

  assign out_quot = out_quot_q;
  assign out_rem = out_rem_q;
  assign out_dbz = out_dbz_q;

`ifdef TYPED_DIV_OVF_FLAG_EN
  logic ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  always_comb begin
    ovf_d = (state_q == PREP) ? (sgn_q && a_q == {1'b1, {(WIDTH-1){1'b0}}} && &b_q) : ovf_q;
    out_ovf_d = (state_q == FIX) ? ovf_q : out_ovf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  assign out_ovf = out_ovf_q;
`endif
endmodule

// File: tb/tb_typed_div_seq.sv
// tb_typed_div_seq: scoreboard bench for typed_div_seq (WIDTH=32 random + WIDTH=4 corners)
module tb_typed_div_seq;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic in_valid = 0, in_ready, in_signed = 0, out_valid, out_ready = 0, out_dbz;
  logic [W-1:0] in_dividend = '0, in_divisor = '0, out_quot, out_rem;
  logic in_valid4 = 0, in_ready4, in_signed4 = 0, out_valid4, out_ready4 = 0, out_dbz4;
  logic [3:0] in_dividend4 = '0, in_divisor4 = '0, out_quot4, out_rem4;
`ifdef TYPED_DIV_OVF_FLAG_EN
  logic out_ovf, out_ovf4;
`endif

  typed_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .out_valid(out_valid),
    .out_ready(out_ready), .out_quot(out_quot), .out_rem(out_rem),
`ifdef TYPED_DIV_OVF_FLAG_EN
    .out_ovf(out_ovf),
`endif
    .out_dbz(out_dbz)
  );

  typed_div_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_signed(in_signed4),
    .in_dividend(in_dividend4), .in_divisor(in_divisor4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_quot(out_quot4), .out_rem(out_rem4),
`ifdef TYPED_DIV_OVF_FLAG_EN
    .out_ovf(out_ovf4),
`endif
    .out_dbz(out_dbz4)
  );

  typedef struct {
    logic [W-1:0] q, r;
    logic dbz, ovf;
    int due;
  } exp_t;
  exp_t sb[$];

  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit hold = 0, seen = 0, hs_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: SV '/' and '%' semantics plus the divide-by-zero and MIN/-1 rules.
  function automatic exp_t model(bit s, logic [W-1:0] a, logic [W-1:0] b, int c);
    exp_t e;
    e.dbz = 0;
    e.ovf = 0;
    e.due = c + 1 + ((b == 0) ? 2 : W + 2);
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1;
    end else if (s && a == MINV && b == '1) begin
      e.q = MINV; e.r = '0; e.ovf = 1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return MINV;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    #1 out_ready = !hold && ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hs_prev) chk("in_ready_after_hs", in_ready, 1);
      hs_prev = 0;
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else begin
          if (!seen) chk("latency", cyc, sb[0].due);
          seen = 1;
          chk("quot", out_quot, sb[0].q);
          chk("rem", out_rem, sb[0].r);
          chk("dbz", out_dbz, sb[0].dbz);
`ifdef TYPED_DIV_OVF_FLAG_EN
          chk("ovf", out_ovf, sb[0].ovf);
`endif
          chk("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
            hs_prev = 1;
          end
        end
      end
    end
  end

  task automatic issue(bit s, logic [W-1:0] a, logic [W-1:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_signed = s; in_dividend = a; in_divisor = b;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 0;
      return;
    end
    sb.push_back(model(s, a, b, cyc));
    @(posedge clk);
    #1 in_valid = 0; in_signed = 1'($urandom); in_dividend = $urandom; in_divisor = $urandom;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 64'(sb.size()), 0);
  endtask

  task automatic op4(bit s, logic [3:0] a, logic [3:0] b, logic [3:0] eq, logic [3:0] er, bit ed, bit eo);
    int t = 0;
    @(negedge clk);
    chk("w4_in_ready", in_ready4, 1);
    in_valid4 = 1; in_signed4 = s; in_dividend4 = a; in_divisor4 = b;
    @(posedge clk);
    #1 in_valid4 = 0; in_dividend4 = 4'($urandom); in_divisor4 = 4'($urandom);
    while (!out_valid4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("w4_valid", out_valid4, 1);
    chk("w4_quot", out_quot4, eq);
    chk("w4_rem", out_rem4, er);
    chk("w4_dbz", out_dbz4, ed);
`ifdef TYPED_DIV_OVF_FLAG_EN
    chk("w4_ovf", out_ovf4, eo);
`else
    if (eo) t = 0;
`endif
    out_ready4 = 1;
    @(negedge clk);
    out_ready4 = 0;
  endtask

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", out_quot, 0);
    chk("rst_rem", out_rem, 0);
    chk("rst_dbz", out_dbz, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    issue(1, -32'sd12, 32'sd3);
    issue(0, 32'hFFFF_FFF4, 32'd3);
    issue(1, -32'sd13, 32'sd4);
    issue(0, 32'd7, 32'd0);
    issue(1, 32'd7, 32'd0);
    issue(1, MINV, '1);
    for (int i = 0; i < 40; i++) issue(1'($urandom), pick(), pick());
    wait_idle();

    hold = 1;
    issue(1, 32'd100, -32'sd7);
    for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    hold = 0;
    wait_idle();

    issue(0, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    sb.delete();
    seen = 0;
    hs_prev = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quot", out_quot, 0);
    chk("abort_rem", out_rem, 0);
    chk("abort_dbz", out_dbz, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    issue(1, -32'sd100, 32'sd9);
    issue(0, 32'd12345, 32'd11);
    wait_idle();

    op4(1, 4'b0100, 4'b0011, 4'd1, 4'd1, 0, 0);
    op4(1, 4'b1000, 4'b1111, 4'b1000, 4'd0, 0, 1);
    op4(1, 4'b1001, 4'b0010, 4'b1101, 4'b1111, 0, 0);
    op4(0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
